rv32i_ctrl_exec: RTL and testbench

Combined control decoder and execute stage for the five-stage RV32I pipeline. It decodes opcode/funct fields in the decode (D) stage into datapath controls. It latches controls and operands into the D→E pipeline register. In the execute (E) stage it computes the ALU result and the branch/jump redirect (`pcsel`). It sits between the instruction decoder/register file and the memory-stage register.

---
 rtl/rv32i_ctrl_exec_if.sv | 38 +++
 rtl/rv32i_ctrl_exec.sv | 158 +++++++++++++++
 tb/tb_rv32i_ctrl_exec.sv | 202 ++++++++++++++++++++
 3 files changed

// File: rtl/rv32i_ctrl_exec_if.sv
// D-stage inputs, D-stage controls and E-stage results of the RV32I control/execute block.
// The pipeline drives through the master modport; the block attaches through the slave modport.
interface rv32i_ctrl_exec_if;
  logic        flush;
  logic [6:0]  opcode_d;
  logic [2:0]  funct3_d;
  logic [6:0]  funct7_d;
  logic [31:0] imm_d;
  logic [31:0] pc_d;
  logic [31:0] rs1_data_d;
  logic [31:0] rs2_data_d;

  logic        regwen_d;
  logic        memrw_d;
  logic [1:0]  wbsel_d;
  logic [1:0]  access_size_d;

  logic [31:0] alu_out_e;
  logic        pcsel_e;
  logic        regwen_e;
  logic        memrw_e;
  logic [1:0]  wbsel_e;
  logic [1:0]  access_size_e;
  logic [2:0]  funct3_e;
  logic [31:0] rs2_data_e;

  modport master (
    output flush, opcode_d, funct3_d, funct7_d, imm_d, pc_d, rs1_data_d, rs2_data_d,
    input  regwen_d, memrw_d, wbsel_d, access_size_d,
    input  alu_out_e, pcsel_e, regwen_e, memrw_e, wbsel_e, access_size_e, funct3_e, rs2_data_e
  );

  modport slave (
    input  flush, opcode_d, funct3_d, funct7_d, imm_d, pc_d, rs1_data_d, rs2_data_d,
    output regwen_d, memrw_d, wbsel_d, access_size_d,
    output alu_out_e, pcsel_e, regwen_e, memrw_e, wbsel_e, access_size_e, funct3_e, rs2_data_e
  );
endinterface

// File: rtl/rv32i_ctrl_exec.sv
// RV32I decode controls, D->E pipeline register and execute stage (ALU + branch/jump redirect).
// Optional macro EXEC_SELF_FLUSH_EN: bubble the instruction that follows a taken redirect.
module rv32i_ctrl_exec (
  input logic              clock,
  input logic              reset,
  rv32i_ctrl_exec_if.slave bus
);
  localparam logic [6:0] OPC_LUI    = 7'b0110111;
  localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
  localparam logic [6:0] OPC_JAL    = 7'b1101111;
  localparam logic [6:0] OPC_JALR   = 7'b1100111;
  localparam logic [6:0] OPC_BRANCH = 7'b1100011;
  localparam logic [6:0] OPC_LOAD   = 7'b0000011;
  localparam logic [6:0] OPC_STORE  = 7'b0100011;
  localparam logic [6:0] OPC_OPIMM  = 7'b0010011;
  localparam logic [6:0] OPC_OP     = 7'b0110011;

  typedef enum logic [1:0] {WB_DMEM = 2'd0, WB_ALU = 2'd1, WB_PC4 = 2'd2} wbsel_t;

  typedef struct packed {
    logic [6:0]  opcode;
    logic [2:0]  funct3;
    logic        alt;          // funct7[5]: SUB / SRA(I)
    logic [31:0] pc;
    logic [31:0] imm;
    logic [31:0] rs1;
    logic [31:0] rs2;
    logic        regwen;
    logic        memrw;
    wbsel_t      wbsel;
    logic [1:0]  access_size;
  } ereg_t;

  logic       d_regwen, d_memrw;
  wbsel_t     d_wbsel;
  logic [1:0] d_access_size;

  always_comb begin
    // NOTE: every signal gets a default before the case so no path can infer a latch.
    d_regwen      = 1'b0;
    d_memrw       = 1'b0;
    d_wbsel       = WB_DMEM;
    d_access_size = 2'd0;
    case (bus.opcode_d)
      OPC_LUI, OPC_AUIPC, OPC_OPIMM, OPC_OP: begin
        d_regwen = 1'b1;
        d_wbsel  = WB_ALU;
      end
      OPC_JAL, OPC_JALR: begin
        d_regwen = 1'b1;
        d_wbsel  = WB_PC4;
      end
      OPC_LOAD: begin
        d_regwen      = 1'b1;
        d_access_size = bus.funct3_d[1:0];
      end
      OPC_STORE: begin
        d_memrw       = 1'b1;
        d_access_size = bus.funct3_d[1:0];
      end
      default: ;
    endcase
  end

  assign bus.regwen_d      = d_regwen;
  assign bus.memrw_d       = d_memrw;
  assign bus.wbsel_d       = d_wbsel;
  assign bus.access_size_d = d_access_size;

  // Only funct7[5] carries meaning in RV32I; the rest is deliberately ignored.
  logic unused_funct7;
  assign unused_funct7 = ^{bus.funct7_d[6], bus.funct7_d[4:0]};

  ereg_t e;
  logic  pcsel;
  logic  self_flush;

`ifdef EXEC_SELF_FLUSH_EN
  assign self_flush = pcsel;
`else
  assign self_flush = 1'b0;
`endif

  always_ff @(posedge clock) begin
    // NOTE: sequential state uses non-blocking assignment so all registers update together.
    if (reset || bus.flush || self_flush) begin
      e <= '0;
    end else begin
      e <= '{opcode: bus.opcode_d, funct3: bus.funct3_d, alt: bus.funct7_d[5],
             pc: bus.pc_d, imm: bus.imm_d, rs1: bus.rs1_data_d, rs2: bus.rs2_data_d,
             regwen: d_regwen, memrw: d_memrw, wbsel: d_wbsel, access_size: d_access_size};
    end
  end

  logic [31:0] op_a, op_b, sum, sra_res, alu;
  logic [4:0]  shamt;
  logic        eq, lt, ltu, taken;

  assign op_a    = (e.opcode == OPC_AUIPC || e.opcode == OPC_JAL || e.opcode == OPC_BRANCH) ? e.pc : e.rs1;
  assign op_b    = (e.opcode == OPC_OP) ? e.rs2 : e.imm;
  assign sum     = op_a + op_b;
  assign shamt   = op_b[4:0];
  assign sra_res = $signed(op_a) >>> shamt;

  assign eq  = (e.rs1 == e.rs2);
  assign lt  = ($signed(e.rs1) < $signed(e.rs2));
  assign ltu = (e.rs1 < e.rs2);

  // funct3[2] picks the magnitude compares, funct3[1] their unsigned form, funct3[0] inverts.
  always_comb begin
    taken = 1'b0;
    if (e.funct3[2])       taken = (e.funct3[1] ? ltu : lt) ^ e.funct3[0];
    else if (!e.funct3[1]) taken = eq ^ e.funct3[0];
  end

  always_comb begin
    alu   = 32'd0;
    pcsel = 1'b0;
    case (e.opcode)
      OPC_LUI:                      alu = e.imm;
      OPC_AUIPC, OPC_LOAD, OPC_STORE: alu = sum;
      OPC_JAL: begin
        alu   = sum;
        pcsel = 1'b1;
      end
      OPC_JALR: begin
        alu   = {sum[31:1], 1'b0};
        pcsel = 1'b1;
      end
      OPC_BRANCH: begin
        alu   = sum;
        pcsel = taken;
      end
      OPC_OPIMM, OPC_OP: begin
        case (e.funct3)
          3'b000:  alu = (e.opcode == OPC_OP && e.alt) ? op_a - op_b : sum;
          3'b001:  alu = op_a << shamt;
          3'b010:  alu = {31'd0, $signed(op_a) < $signed(op_b)};
          3'b011:  alu = {31'd0, op_a < op_b};
          3'b100:  alu = op_a ^ op_b;
          3'b101:  alu = e.alt ? sra_res : op_a >> shamt;
          3'b110:  alu = op_a | op_b;
          default: alu = op_a & op_b;
        endcase
      end
      default: ;
    endcase
  end

  assign bus.alu_out_e     = alu;
  assign bus.pcsel_e       = pcsel;
  assign bus.regwen_e      = e.regwen;
  assign bus.memrw_e       = e.memrw;
  assign bus.wbsel_e       = e.wbsel;
  assign bus.access_size_e = e.access_size;
  assign bus.funct3_e      = e.funct3;
  assign bus.rs2_data_e    = e.rs2;
endmodule

// File: tb/tb_rv32i_ctrl_exec.sv
// Scoreboard bench for rv32i_ctrl_exec: a driver pushes model predictions, a monitor pops and compares.
// Honors EXEC_SELF_FLUSH_EN the same way the design does.
module tb_rv32i_ctrl_exec;
  localparam logic [6:0] LUI = 7'b0110111, AUIPC = 7'b0010111, JAL = 7'b1101111, JALR = 7'b1100111;
  localparam logic [6:0] BRANCH = 7'b1100011, LOAD = 7'b0000011, STORE = 7'b0100011;
  localparam logic [6:0] OPIMM = 7'b0010011, OP = 7'b0110011, FENCE = 7'b0001111, SYSTEM = 7'b1110011;

`ifdef EXEC_SELF_FLUSH_EN
  localparam bit SELF_FLUSH = 1'b1;
`else
  localparam bit SELF_FLUSH = 1'b0;
`endif

  logic clock = 1'b0;
  logic reset;
  always #5 clock = ~clock;

  rv32i_ctrl_exec_if bus ();
  rv32i_ctrl_exec dut (.clock(clock), .reset(reset), .bus(bus));

  typedef struct packed {
    logic [6:0] op; logic [2:0] f3; logic [6:0] f7;
    logic [31:0] imm, pc, rs1, rs2;
    logic fl, rst;
  } stim_t;

  typedef struct packed {
    logic [15:0] id;
    logic d_regwen, d_memrw; logic [1:0] d_wbsel, d_asize;
    logic regwen, memrw, pcsel; logic [1:0] wbsel, asize;
    logic [2:0] f3; logic chk_f3;
    logic [31:0] alu, rs2;
  } exp_t;

  exp_t q[$];
  int   n_vec = 0, n_err = 0;
  logic last_pcsel = 1'b0;
  int   next_id = 0;

  task automatic check(input string name, input int id, input logic [31:0] act, input logic [31:0] want);
    n_vec++;
    if (act !== want) begin
      n_err++;
      $display("FAIL v%0d %s: got %h expected %h", id, name, act, want);
    end
  endtask

  function automatic logic [31:0] arith(logic [2:0] f3, logic alt, logic is_op, logic [31:0] a, logic [31:0] b);
    logic signed [31:0] sa;
    logic [4:0] sh;
    sa = a;
    sh = b[4:0];
    case (f3)
      3'd0: return (is_op && alt) ? a - b : a + b;
      3'd1: return a << sh;
      3'd2: return ($signed(a) < $signed(b)) ? 32'd1 : 32'd0;
      3'd3: return (a < b) ? 32'd1 : 32'd0;
      3'd4: return a ^ b;
      3'd5: begin
        if (alt) return sa >>> sh;
        return a >> sh;
      end
      3'd6: return a | b;
      default: return a & b;
    endcase
  endfunction

  function automatic logic branch_taken(logic [2:0] f3, logic [31:0] a, logic [31:0] b);
    case (f3)
      3'd0: return a == b;
      3'd1: return a != b;
      3'd4: return $signed(a) < $signed(b);
      3'd5: return $signed(a) >= $signed(b);
      3'd6: return a < b;
      3'd7: return a >= b;
      default: return 1'b0;
    endcase
  endfunction

  function automatic exp_t model(stim_t s, logic prev_pcsel, int id);
    exp_t e;
    e = '0;
    e.id = id[15:0];
    case (s.op)
      LUI:    begin e.d_regwen = 1; e.d_wbsel = 1; e.alu = s.imm; end
      AUIPC:  begin e.d_regwen = 1; e.d_wbsel = 1; e.alu = s.pc + s.imm; end
      JAL:    begin e.d_regwen = 1; e.d_wbsel = 2; e.alu = s.pc + s.imm; e.pcsel = 1; end
      JALR:   begin e.d_regwen = 1; e.d_wbsel = 2; e.alu = (s.rs1 + s.imm) & 32'hFFFF_FFFE; e.pcsel = 1; end
      BRANCH: begin e.alu = s.pc + s.imm; e.pcsel = branch_taken(s.f3, s.rs1, s.rs2); e.chk_f3 = 1; end
      LOAD:   begin e.d_regwen = 1; e.d_asize = s.f3[1:0]; e.alu = s.rs1 + s.imm; e.chk_f3 = 1; end
      STORE:  begin e.d_memrw = 1; e.d_asize = s.f3[1:0]; e.alu = s.rs1 + s.imm; e.chk_f3 = 1; end
      OPIMM:  begin e.d_regwen = 1; e.d_wbsel = 1; e.alu = arith(s.f3, s.f7[5], 1'b0, s.rs1, s.imm); end
      OP:     begin e.d_regwen = 1; e.d_wbsel = 1; e.alu = arith(s.f3, s.f7[5], 1'b1, s.rs1, s.rs2); end
      default: ;
    endcase
    e.regwen = e.d_regwen; e.memrw = e.d_memrw; e.wbsel = e.d_wbsel; e.asize = e.d_asize;
    e.f3 = s.f3; e.rs2 = s.rs2;
    if (s.rst || s.fl || (SELF_FLUSH && prev_pcsel)) begin
      e.regwen = 0; e.memrw = 0; e.pcsel = 0; e.wbsel = 0; e.asize = 0;
      e.f3 = 0; e.chk_f3 = 1; e.alu = 0; e.rs2 = 0;
    end
    return e;
  endfunction

  function automatic stim_t mk(logic [6:0] op, logic [2:0] f3, logic [6:0] f7, logic [31:0] imm,
                               logic [31:0] pc, logic [31:0] rs1, logic [31:0] rs2, logic fl, logic rst);
    stim_t s;
    s.op = op; s.f3 = f3; s.f7 = f7; s.imm = imm; s.pc = pc; s.rs1 = rs1; s.rs2 = rs2;
    s.fl = fl; s.rst = rst;
    return s;
  endfunction

  // Drive one instruction for one clock edge and queue what E must show after that edge.
  task automatic apply(input stim_t s);
    exp_t e;
    reset = s.rst;
    bus.flush = s.fl; bus.opcode_d = s.op; bus.funct3_d = s.f3; bus.funct7_d = s.f7;
    bus.imm_d = s.imm; bus.pc_d = s.pc; bus.rs1_data_d = s.rs1; bus.rs2_data_d = s.rs2;
    e = model(s, last_pcsel, next_id);
    next_id++;
    last_pcsel = e.pcsel;
    q.push_back(e);
    @(negedge clock);
  endtask

  // Monitor: just after each edge the D inputs still hold the instruction that entered E.
  initial begin
    exp_t e;
    forever begin
      @(posedge clock);
      #2;
      if (q.size() > 0) begin
        e = q.pop_front();
        check("regwen_d",      e.id, 32'(bus.regwen_d),      32'(e.d_regwen));
        check("memrw_d",       e.id, 32'(bus.memrw_d),       32'(e.d_memrw));
        check("wbsel_d",       e.id, 32'(bus.wbsel_d),       32'(e.d_wbsel));
        check("access_size_d", e.id, 32'(bus.access_size_d), 32'(e.d_asize));
        check("alu_out_e",     e.id, bus.alu_out_e,          e.alu);
        check("pcsel_e",       e.id, 32'(bus.pcsel_e),       32'(e.pcsel));
        check("regwen_e",      e.id, 32'(bus.regwen_e),      32'(e.regwen));
        check("memrw_e",       e.id, 32'(bus.memrw_e),       32'(e.memrw));
        check("wbsel_e",       e.id, 32'(bus.wbsel_e),       32'(e.wbsel));
        check("access_size_e", e.id, 32'(bus.access_size_e), 32'(e.asize));
        check("rs2_data_e",    e.id, bus.rs2_data_e,         e.rs2);
        if (e.chk_f3) check("funct3_e", e.id, 32'(bus.funct3_e), 32'(e.f3));
      end
    end
  end

  initial begin
    logic [6:0] ops [11];
    stim_t s;
    ops = '{LUI, AUIPC, JAL, JALR, BRANCH, LOAD, STORE, OPIMM, OP, FENCE, SYSTEM};

    // Reset held two cycles with a valid ADD presented.
    apply(mk(OP, 3'd0, 7'h00, 32'd0, 32'd0, 32'd5, 32'd7, 1'b0, 1'b1));
    apply(mk(OP, 3'd0, 7'h00, 32'd0, 32'd0, 32'd5, 32'd7, 1'b0, 1'b1));
    // ADD / SUB.
    apply(mk(OP, 3'd0, 7'h00, 32'd0, 32'd0, 32'd5, 32'd7, 1'b0, 1'b0));
    apply(mk(OP, 3'd0, 7'h20, 32'd0, 32'd0, 32'd5, 32'd7, 1'b0, 1'b0));
    // SRAI / SRLI.
    apply(mk(OPIMM, 3'd5, 7'h20, 32'd4, 32'd0, 32'h8000_0000, 32'd0, 1'b0, 1'b0));
    apply(mk(OPIMM, 3'd5, 7'h00, 32'd4, 32'd0, 32'h8000_0000, 32'd0, 1'b0, 1'b0));
    // BLT taken, filler, BLTU not taken.
    apply(mk(BRANCH, 3'd4, 7'h00, 32'd8, 32'h0100_0000, 32'hFFFF_FFFF, 32'd1, 1'b0, 1'b0));
    apply(mk(FENCE, 3'd0, 7'h00, 32'd0, 32'd0, 32'd0, 32'd0, 1'b0, 1'b0));
    apply(mk(BRANCH, 3'd6, 7'h00, 32'd8, 32'h0100_0000, 32'hFFFF_FFFF, 32'd1, 1'b0, 1'b0));
    // JALR, filler, SW.
    apply(mk(JALR, 3'd0, 7'h00, 32'd4, 32'h0000_2000, 32'h0100_0011, 32'd0, 1'b0, 1'b0));
    apply(mk(FENCE, 3'd0, 7'h00, 32'd0, 32'd0, 32'd0, 32'd0, 1'b0, 1'b0));
    apply(mk(STORE, 3'd2, 7'h00, 32'd8, 32'd0, 32'h100, 32'hCAFE_BABE, 1'b0, 1'b0));
    // Flushed store, then JAL followed by ADD.
    apply(mk(STORE, 3'd2, 7'h00, 32'd8, 32'd0, 32'h100, 32'h1234_5678, 1'b1, 1'b0));
    apply(mk(JAL, 3'd0, 7'h00, 32'h40, 32'h0000_1000, 32'd0, 32'd0, 1'b0, 1'b0));
    apply(mk(OP, 3'd0, 7'h00, 32'd0, 32'd0, 32'd3, 32'd4, 1'b0, 1'b0));
    // Back-to-back flushes.
    apply(mk(OP, 3'd0, 7'h00, 32'd0, 32'd0, 32'd1, 32'd1, 1'b1, 1'b0));
    apply(mk(LOAD, 3'd1, 7'h00, 32'd2, 32'd0, 32'd10, 32'd0, 1'b1, 1'b0));

    for (int i = 0; i < 400; i++) begin
      s.op  = ($urandom_range(0, 19) == 0) ? 7'($urandom) : ops[$urandom_range(0, 10)];
      s.f3  = 3'($urandom);
      s.f7  = $urandom_range(0, 1) ? 7'h20 : 7'h00;
      s.imm = ($urandom_range(0, 3) == 0) ? 32'($urandom_range(0, 40)) : $urandom;
      s.pc  = {$urandom, 2'b00};
      s.rs1 = ($urandom_range(0, 3) == 0) ? 32'($urandom_range(0, 3)) : $urandom;
      s.rs2 = ($urandom_range(0, 3) == 0) ? s.rs1 : $urandom;
      s.fl  = ($urandom_range(0, 9) == 0);
      s.rst = ($urandom_range(0, 39) == 0);
      apply(s);
    end

    for (int i = 0; i < 5 && q.size() > 0; i++) @(negedge clock);
    if (q.size() != 0) begin
      n_vec++;
      n_err++;
      $display("FAIL drain: %0d predictions left, expected 0", q.size());
    end
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
